// File: rtl/seg_scan_ctrl_if.sv
// Host-side write/config signals and display-side scan outputs of the
// seven-segment scan controller, bundled so both ends share one definition.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      wr_en;
  logic [4*NUM_DIGITS-1:0]   wr_data;
  logic [NUM_DIGITS-1:0]     digit_en;
  logic                      lz_blank;
  logic [3:0]                dig_data;
  logic                      dig_write;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output wr_en, wr_data, digit_en, lz_blank,
    input  dig_data, dig_write, an, frame_done
  );

  modport slave (
    input  wr_en, wr_data, digit_en, lz_blank,
    output dig_data, dig_write, an, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit seven-segment display with
// a blanking gap per digit and frame-aligned double-buffered data updates.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic           clk,
  input  logic           reset,
  seg_scan_ctrl_if.slave bus
);

  localparam int MAX_CNT = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int DW      = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] SHOW_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t               state, state_n;
  logic [IW-1:0]        idx, idx_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [DW-1:0]        shadow, shadow_n;
  logic [DW-1:0]        active, active_n;
  logic                 pending, pending_n;
  logic                 wrap;

  logic [3:0]           dig_data_q, dig_data_n;
  logic                 dig_write_q, dig_write_n;
  logic [NUM_DIGITS-1:0] an_q, an_n;
  logic                 frame_done_q, frame_done_n;

  logic                 lz_zero;
  logic                 vis;

  // All state and the outputs are flops; outputs are precomputed from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= BLANK;
      idx          <= '0;
      cnt          <= '0;
      shadow       <= '0;
      active       <= '0;
      pending      <= 1'b0;
      dig_data_q   <= 4'd0;
      dig_write_q  <= 1'b0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      shadow       <= shadow_n;
      active       <= active_n;
      pending      <= pending_n;
      dig_data_q   <= dig_data_n;
      dig_write_q  <= dig_write_n;
      an_q         <= an_n;
      frame_done_q <= frame_done_n;
    end
  end

  // Scan sequencing plus the shadow/active buffer swap at the frame wrap.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt + CW'(1);
    shadow_n  = shadow;
    active_n  = active;
    pending_n = pending;
    wrap      = 1'b0;

    case (state)
      BLANK: begin
        if ((BLANK_CYC == 0) || (cnt == BLANK_END)) begin
          state_n = SHOW;
          cnt_n   = '0;
        end
      end
      SHOW: begin
        if (cnt == SHOW_END) begin
          cnt_n   = '0;
          state_n = (BLANK_CYC == 0) ? SHOW : BLANK;
          if (idx == LAST_IDX) begin
            idx_n = '0;
            wrap  = 1'b1;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      default: begin
        state_n = BLANK;
        cnt_n   = '0;
      end
    endcase

    // A write landing on the wrap cycle goes straight to the display buffer.
    if (bus.wr_en) begin
      shadow_n  = bus.wr_data;
      pending_n = !wrap;
      if (wrap) active_n = bus.wr_data;
    end else if (wrap && pending) begin
      active_n  = shadow;
      pending_n = 1'b0;
    end
  end

  // Output decode for the coming cycle, including leading-zero suppression.
  always_comb begin
    lz_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(idx_n)) && (active_n[4*k +: 4] != 4'd0)) lz_zero = 1'b0;
    end
    vis = bus.digit_en[idx_n] && !(bus.lz_blank && (idx_n != '0) && lz_zero);

    dig_data_n   = 4'd0;
    dig_write_n  = 1'b0;
    an_n         = '0;
    frame_done_n = wrap;
    if (state_n == SHOW) begin
      dig_data_n  = active_n[{idx_n, 2'b00} +: 4];
      dig_write_n = vis;
      an_n        = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_n;
    end
  end

  assign bus.dig_data   = dig_data_q;
  assign bus.dig_write  = dig_write_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule
